// File: rtl/fu_alu_pkg.sv
// Shared types for the integer ALU functional unit: opcodes, condition flags,
// datapath widths and the completion record queued towards the ROB.
package fu_alu_pkg;

  localparam int GPR_SIZE     = 64;
  localparam int ROB_IDX_SIZE = 4;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_ORR    = 4'd3,
    ALU_EOR    = 4'd4,
    ALU_PASS_A = 4'd5,
    ALU_LSL    = 4'd6,
    ALU_LSR    = 4'd7,
    ALU_ASR    = 4'd8,
    ALU_MUL    = 4'd9
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef struct packed {
    logic [ROB_IDX_SIZE-1:0] dst_rob_index;
    logic [GPR_SIZE-1:0]     value;
    logic                    set_nzcv;
    nzcv_t                   nzcv;
  } fu_result_t;

endpackage

// File: rtl/fu_alu_resq.sv
// In-order result queue between the ALU exec stage and the ROB completion port.
// Supports simultaneous push/pop, a synchronous flush and reports free slots.
module fu_alu_resq
  import fu_alu_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int IDX_SIZE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  fu_result_t        push_data,
  input  logic              pop,
  output fu_result_t        head,
  output logic              head_valid,
  output logic [IDX_SIZE:0] free_slots
);

  localparam logic [IDX_SIZE:0] DEPTH_C = (IDX_SIZE+1)'(DEPTH);

  fu_result_t          mem [DEPTH];
  logic [IDX_SIZE-1:0] wr_ptr_reg;
  logic [IDX_SIZE-1:0] rd_ptr_reg;
  logic [IDX_SIZE:0]   count_reg;
  logic                do_push;
  logic                do_pop;

  // A push into a full queue is still legal when the head leaves in the same cycle.
  always_comb begin
    do_pop     = pop && (count_reg != '0);
    do_push    = push && ((count_reg != DEPTH_C) || do_pop);
    head       = mem[rd_ptr_reg];
    head_valid = (count_reg != '0);
    free_slots = DEPTH_C - count_reg;
  end

  // Storage write; entries are only meaningful while counted, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + IDX_SIZE'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + IDX_SIZE'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (IDX_SIZE+1)'(1);
        2'b01:   count_reg <= count_reg - (IDX_SIZE+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fu_alu.sv
// Integer ALU functional unit: one exec stage fed by the reservation station,
// followed by a small result queue drained by the ROB with valid/ready.
// Optional multiplier support is enabled with the FU_ALU_MUL_EN macro.
module fu_alu
  import fu_alu_pkg::*;
#(
  parameter int RESQ_DEPTH    = 4,
  parameter int RESQ_IDX_SIZE = 2,
  parameter int MUL_LATENCY   = 3
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_rs_start,
  input  alu_op_t                 in_rs_op,
  input  logic [GPR_SIZE-1:0]     in_rs_val_a,
  input  logic [GPR_SIZE-1:0]     in_rs_val_b,
  input  logic [ROB_IDX_SIZE-1:0] in_rs_dst_rob_index,
  input  logic                    in_rs_set_nzcv,
  input  nzcv_t                   in_rs_nzcv,
  input  logic                    in_rob_is_mispred,
  input  logic                    in_rob_ready,
  output logic                    out_rs_ready,
  output logic                    out_rob_done,
  output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
  output logic [GPR_SIZE-1:0]     out_rob_value,
  output logic                    out_rob_set_nzcv,
  output nzcv_t                   out_rob_nzcv
);

  localparam int CNT_W = $clog2(MUL_LATENCY + 1);
  localparam int FW    = RESQ_IDX_SIZE + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_STALL    = 2'd2,
    ST_MUL_WAIT = 2'd3
  } e_state_t;

  // Pure datapath: result and flags for one op. Unknown ops give 0 and pass flags through.
  function automatic fu_result_t fu_alu_exec(
    input alu_op_t                 op,
    input logic [GPR_SIZE-1:0]     a,
    input logic [GPR_SIZE-1:0]     b,
    input logic [ROB_IDX_SIZE-1:0] dst,
    input logic                    set_nzcv,
    input nzcv_t                   nzcv_in
  );
    logic [GPR_SIZE:0]   sum;
    logic [GPR_SIZE-1:0] res;
    logic                c;
    logic                v;
    logic                known;
    nzcv_t               flags;
    fu_result_t          r;
    sum   = '0;
    res   = '0;
    c     = 1'b0;
    v     = 1'b0;
    known = 1'b1;
    case (op)
      ALU_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        res = sum[GPR_SIZE-1:0];
        c   = sum[GPR_SIZE];
        v   = (a[GPR_SIZE-1] == b[GPR_SIZE-1]) && (res[GPR_SIZE-1] != a[GPR_SIZE-1]);
      end
      ALU_SUB: begin
        sum = {1'b0, a} - {1'b0, b};
        res = sum[GPR_SIZE-1:0];
        c   = ~sum[GPR_SIZE];  // no-borrow: A >= B unsigned
        v   = (a[GPR_SIZE-1] != b[GPR_SIZE-1]) && (res[GPR_SIZE-1] != a[GPR_SIZE-1]);
      end
      ALU_AND:    res = a & b;
      ALU_ORR:    res = a | b;
      ALU_EOR:    res = a ^ b;
      ALU_PASS_A: res = a;
      ALU_LSL:    res = a << b[5:0];
      ALU_LSR:    res = a >> b[5:0];
      ALU_ASR:    res = $signed(a) >>> b[5:0];
`ifdef FU_ALU_MUL_EN
      ALU_MUL:    res = a * b;  // low GPR_SIZE bits of the product
`endif
      default:    known = 1'b0;
    endcase
    flags.n         = res[GPR_SIZE-1];
    flags.z         = (res == '0);
    flags.c         = c;
    flags.v         = v;
    r.dst_rob_index = dst;
    r.value         = known ? res : '0;
    r.set_nzcv      = set_nzcv;
    r.nzcv          = (known && set_nzcv) ? flags : nzcv_in;
    return r;
  endfunction

  e_state_t                e_state_reg;
  logic [CNT_W-1:0]        mul_cnt_reg;
  alu_op_t                 e_op_reg;
  logic [GPR_SIZE-1:0]     e_a_reg;
  logic [GPR_SIZE-1:0]     e_b_reg;
  logic [ROB_IDX_SIZE-1:0] e_dst_reg;
  logic                    e_set_reg;
  nzcv_t                   e_nzcv_reg;

  fu_result_t              e_result;
  fu_result_t              head;
  logic                    head_valid;
  logic [FW-1:0]           free_slots;
  logic                    e_valid;
  logic                    e_done;
  logic                    mul_busy;
  logic                    pop;
  logic                    push;
  logic                    accept;
  logic                    start_is_mul;

  // Exec-stage control: when the held op can retire into the queue and when a new op fits.
  always_comb begin
    e_result = fu_alu_exec(e_op_reg, e_a_reg, e_b_reg, e_dst_reg, e_set_reg, e_nzcv_reg);
    e_valid  = (e_state_reg != ST_IDLE);
    mul_busy = (e_state_reg == ST_MUL_WAIT) && (mul_cnt_reg < CNT_W'(MUL_LATENCY));
    e_done   = (e_state_reg == ST_EXEC) || (e_state_reg == ST_STALL) ||
               ((e_state_reg == ST_MUL_WAIT) && (mul_cnt_reg == CNT_W'(MUL_LATENCY)));
    pop      = head_valid && in_rob_ready;
    push     = e_done && !in_rob_is_mispred && ((free_slots != '0) || pop);
    accept   = in_rs_start && !in_rob_is_mispred && (!e_valid || push);
`ifdef FU_ALU_MUL_EN
    start_is_mul = (in_rs_op == ALU_MUL);
`else
    start_is_mul = 1'b0;
`endif
    // Two spare slots cover the op the RS may issue before it sees ready drop.
    out_rs_ready = !mul_busy && (free_slots >= (e_valid ? FW'(3) : FW'(2)));
  end

  // Exec-stage FSM and operand latch; reset beats flush, flush beats a new issue.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      e_state_reg <= ST_IDLE;
      mul_cnt_reg <= '0;
      e_op_reg    <= ALU_ADD;
      e_a_reg     <= '0;
      e_b_reg     <= '0;
      e_dst_reg   <= '0;
      e_set_reg   <= 1'b0;
      e_nzcv_reg  <= '0;
    end else if (in_rob_is_mispred) begin
      e_state_reg <= ST_IDLE;
      mul_cnt_reg <= '0;
    end else if (accept) begin
      e_op_reg    <= in_rs_op;
      e_a_reg     <= in_rs_val_a;
      e_b_reg     <= in_rs_val_b;
      e_dst_reg   <= in_rs_dst_rob_index;
      e_set_reg   <= in_rs_set_nzcv;
      e_nzcv_reg  <= in_rs_nzcv;
      if (start_is_mul) begin
        // Operands stay frozen in E, so the multiplier has MUL_LATENCY cycles to settle.
        e_state_reg <= ST_MUL_WAIT;
        mul_cnt_reg <= CNT_W'(1);
      end else begin
        e_state_reg <= ST_EXEC;
        mul_cnt_reg <= '0;
      end
    end else if (push) begin
      e_state_reg <= ST_IDLE;
      mul_cnt_reg <= '0;
    end else if (e_done) begin
      e_state_reg <= ST_STALL;  // result ready but the queue is full
    end else if (e_state_reg == ST_MUL_WAIT) begin
      mul_cnt_reg <= mul_cnt_reg + CNT_W'(1);
    end
  end

  fu_alu_resq #(
    .DEPTH    (RESQ_DEPTH),
    .IDX_SIZE (RESQ_IDX_SIZE)
  ) u_resq (
    .clk        (in_clk),
    .rst_n      (in_rst),
    .flush      (in_rob_is_mispred),
    .push       (push),
    .push_data  (e_result),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .free_slots (free_slots)
  );

  // Present the queue head; data is forced to zero while nothing is valid.
  always_comb begin
    out_rob_done          = head_valid;
    out_rob_dst_rob_index = head_valid ? head.dst_rob_index : '0;
    out_rob_value         = head_valid ? head.value : '0;
    out_rob_set_nzcv      = head_valid && head.set_nzcv;
    out_rob_nzcv          = head_valid ? head.nzcv : '0;
  end

endmodule

// File: tb/tb_fu_alu.sv
// Directed testbench for fu_alu; expectations follow FU_ALU_MUL_EN when defined.
module tb_fu_alu;
  import fu_alu_pkg::*;

  logic                    in_clk;
  logic                    in_rst;
  logic                    in_rs_start;
  alu_op_t                 in_rs_op;
  logic [GPR_SIZE-1:0]     in_rs_val_a;
  logic [GPR_SIZE-1:0]     in_rs_val_b;
  logic [ROB_IDX_SIZE-1:0] in_rs_dst_rob_index;
  logic                    in_rs_set_nzcv;
  nzcv_t                   in_rs_nzcv;
  logic                    in_rob_is_mispred;
  logic                    in_rob_ready;
  logic                    out_rs_ready;
  logic                    out_rob_done;
  logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index;
  logic [GPR_SIZE-1:0]     out_rob_value;
  logic                    out_rob_set_nzcv;
  nzcv_t                   out_rob_nzcv;

  int n_checks = 0;
  int n_errors = 0;

  fu_alu dut (
    .in_clk                (in_clk),
    .in_rst                (in_rst),
    .in_rs_start           (in_rs_start),
    .in_rs_op              (in_rs_op),
    .in_rs_val_a           (in_rs_val_a),
    .in_rs_val_b           (in_rs_val_b),
    .in_rs_dst_rob_index   (in_rs_dst_rob_index),
    .in_rs_set_nzcv        (in_rs_set_nzcv),
    .in_rs_nzcv            (in_rs_nzcv),
    .in_rob_is_mispred     (in_rob_is_mispred),
    .in_rob_ready          (in_rob_ready),
    .out_rs_ready          (out_rs_ready),
    .out_rob_done          (out_rob_done),
    .out_rob_dst_rob_index (out_rob_dst_rob_index),
    .out_rob_value         (out_rob_value),
    .out_rob_set_nzcv      (out_rob_set_nzcv),
    .out_rob_nzcv          (out_rob_nzcv)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic issue(input alu_op_t op, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] dst, input logic set, input logic [3:0] nz);
    in_rs_start         = 1'b1;
    in_rs_op            = op;
    in_rs_val_a         = a;
    in_rs_val_b         = b;
    in_rs_dst_rob_index = dst;
    in_rs_set_nzcv      = set;
    in_rs_nzcv          = nzcv_t'(nz);
    $display("issue op=%0d a=%h b=%h dst=%0d set=%0d nzcv=%b", op, a, b, dst, set, nz);
    step();
    in_rs_start = 1'b0;
  endtask

  // Issue, wait one cycle, then compare the completion at the queue head.
  task automatic run_op(input string tag, input alu_op_t op, input logic [63:0] a,
                        input logic [63:0] b, input logic [3:0] dst, input logic set,
                        input logic [3:0] nz_in, input logic [63:0] exp_val,
                        input logic [3:0] exp_nz);
    issue(op, a, b, dst, set, nz_in);
    step();
    check({tag, ".done"}, 64'(out_rob_done), 64'd1);
    check({tag, ".dst"},  64'(out_rob_dst_rob_index), 64'(dst));
    check({tag, ".val"},  out_rob_value, exp_val);
    check({tag, ".set"},  64'(out_rob_set_nzcv), 64'(set));
    check({tag, ".nzcv"}, 64'(out_rob_nzcv), 64'(exp_nz));
  endtask

  initial begin
    in_rst              = 1'b0;
    in_rs_start         = 1'b0;
    in_rs_op            = ALU_ADD;
    in_rs_val_a         = '0;
    in_rs_val_b         = '0;
    in_rs_dst_rob_index = '0;
    in_rs_set_nzcv      = 1'b0;
    in_rs_nzcv          = '0;
    in_rob_is_mispred   = 1'b0;
    in_rob_ready        = 1'b1;
    step();
    step();
    check("rst.done",  64'(out_rob_done), 64'd0);
    check("rst.ready", 64'(out_rs_ready), 64'd1);
    check("rst.val",   out_rob_value, 64'd0);
    check("rst.dst",   64'(out_rob_dst_rob_index), 64'd0);
    check("rst.set",   64'(out_rob_set_nzcv), 64'd0);
    check("rst.nzcv",  64'(out_rob_nzcv), 64'd0);
    in_rst = 1'b1;
    step();

    // Basic ops, each completing one cycle after issue
    issue(ALU_ADD, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 4'd3, 1'b1, 4'b0000);
    check("add.latency", 64'(out_rob_done), 64'd0);
    step();
    check("add.done", 64'(out_rob_done), 64'd1);
    check("add.dst",  64'(out_rob_dst_rob_index), 64'd3);
    check("add.val",  out_rob_value, 64'd0);
    check("add.nzcv", 64'(out_rob_nzcv), 64'b0110);
    run_op("sub",     ALU_SUB, 64'd0, 64'd1, 4'd1, 1'b1, 4'b0000, '1, 4'b1000);
    run_op("sub_pass", ALU_SUB, 64'd0, 64'd1, 4'd2, 1'b0, 4'b0101, '1, 4'b0101);
    run_op("add_ovf", ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd4, 1'b1, 4'b0000,
           64'h8000_0000_0000_0000, 4'b1001);
    run_op("eor",     ALU_EOR, 64'hF0, 64'hF0, 4'd5, 1'b1, 4'b0011, 64'd0, 4'b0100);
    run_op("lsl",     ALU_LSL, 64'd1, 64'd63, 4'd6, 1'b1, 4'b0000,
           64'h8000_0000_0000_0000, 4'b1000);
    run_op("asr",     ALU_ASR, 64'h8000_0000_0000_0000, 64'd63, 4'd7, 1'b1, 4'b0000,
           '1, 4'b1000);
    run_op("unknown", alu_op_t'(4'hF), 64'd9, 64'd9, 4'd8, 1'b1, 4'b0011, 64'd0, 4'b0011);
    step();
    check("idle.done", 64'(out_rob_done), 64'd0);

    // Back-to-back issue into a blocked ROB; the late fourth start must still land
    in_rob_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_rs_start         = 1'b1;
      in_rs_op            = ALU_ADD;
      in_rs_val_a         = 64'(i + 10);
      in_rs_val_b         = 64'd0;
      in_rs_dst_rob_index = 4'(i);
      in_rs_set_nzcv      = 1'b0;
      in_rs_nzcv          = '0;
      $display("issue b2b dst=%0d", i);
      step();
      check($sformatf("b2b.ready%0d", i), 64'(out_rs_ready), (i < 2) ? 64'd1 : 64'd0);
    end
    in_rs_start = 1'b0;
    step();
    check("full.ready", 64'(out_rs_ready), 64'd0);
    in_rob_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain.done%0d", i), 64'(out_rob_done), 64'd1);
      check($sformatf("drain.dst%0d", i), 64'(out_rob_dst_rob_index), 64'(i));
      check($sformatf("drain.val%0d", i), out_rob_value, 64'(i + 10));
      step();
    end
    check("drain.empty", 64'(out_rob_done), 64'd0);
    check("drain.ready", 64'(out_rs_ready), 64'd1);

    // Three queued results, then mispredict together with a start
    in_rob_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(ALU_PASS_A, 64'(i), 64'd0, 4'(i), 1'b0, 4'b0000);
    step();
    check("preflush.done", 64'(out_rob_done), 64'd1);
    in_rob_is_mispred = 1'b1;
    issue(ALU_ADD, 64'd99, 64'd1, 4'd7, 1'b0, 4'b0000);
    in_rob_is_mispred = 1'b0;
    check("flush.done",  64'(out_rob_done), 64'd0);
    check("flush.ready", 64'(out_rs_ready), 64'd1);
    in_rob_ready = 1'b1;
    step();
    step();
    check("flush.nostart", 64'(out_rob_done), 64'd0);

    // Multiply: multicycle when enabled, otherwise an unknown single-cycle op
    issue(ALU_MUL, 64'd7, 64'd6, 4'd5, 1'b0, 4'b0000);
`ifdef FU_ALU_MUL_EN
    check("mul.ready1", 64'(out_rs_ready), 64'd0);
    check("mul.done1",  64'(out_rob_done), 64'd0);
    step();
    check("mul.ready2", 64'(out_rs_ready), 64'd0);
    check("mul.done2",  64'(out_rob_done), 64'd0);
    step();
    check("mul.done3",  64'(out_rob_done), 64'd0);
    step();
    check("mul.done",   64'(out_rob_done), 64'd1);
    check("mul.dst",    64'(out_rob_dst_rob_index), 64'd5);
    check("mul.val",    out_rob_value, 64'd42);
`else
    check("mul.done0", 64'(out_rob_done), 64'd0);
    step();
    check("mul.done",  64'(out_rob_done), 64'd1);
    check("mul.dst",   64'(out_rob_dst_rob_index), 64'd5);
    check("mul.val",   out_rob_value, 64'd0);
`endif
    step();
    check("mul.empty", 64'(out_rob_done), 64'd0);

    // Reset mid-operation overrides a concurrent start and mispredict
    in_rob_ready = 1'b0;
    issue(ALU_ADD, 64'd1, 64'd2, 4'd1, 1'b0, 4'b0000);
    issue(ALU_ADD, 64'd3, 64'd4, 4'd2, 1'b0, 4'b0000);
    check("prerst.done", 64'(out_rob_done), 64'd1);
    in_rst            = 1'b0;
    in_rob_is_mispred = 1'b1;
    issue(ALU_ADD, 64'd5, 64'd6, 4'd3, 1'b0, 4'b0000);
    in_rob_is_mispred = 1'b0;
    check("midrst.done",  64'(out_rob_done), 64'd0);
    check("midrst.ready", 64'(out_rs_ready), 64'd1);
    check("midrst.val",   out_rob_value, 64'd0);
    in_rst = 1'b1;
    step();
    check("postrst.done", 64'(out_rob_done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
